alu_issue_arbiter: RTL

Round-robin issue controller that shares one combinational 128-bit ALU (opcodes ADD, SUB, AND, OR, SLL, SRL, XNOR, DIV) between several requesters. It accepts one operation at a time through per-requester valid/ready handshakes and registers the operands onto the ALU ports. It holds them stable for a fixed settle time, extended for DIV as a multicycle path. It captures the result and returns it tagged with the requester ID over a valid/ready response channel.

---
 rtl/alu_issue_arbiter_if.sv | 35 +++
 rtl/alu_issue_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/alu_issue_arbiter_if.sv
// alu_issue_arbiter_if: request, ALU-port and response bundle of the ALU issue arbiter.
// master is the requester/ALU environment side, slave is the arbiter.
interface alu_issue_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 128
);
  localparam int IDW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [4*NUM_REQ-1:0]     req_opcode;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic [5*NUM_REQ-1:0]     req_shift;
  logic [3:0]               alu_opcode;
  logic [WIDTH-1:0]         alu_input1;
  logic [WIDTH-1:0]         alu_input2;
  logic [4:0]               alu_shift;
  logic [WIDTH-1:0]         alu_result;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_result;
  logic                     rsp_err;
  logic                     busy;
  modport master (
    output req_valid, req_opcode, req_a, req_b, req_shift, alu_result, rsp_ready,
    input  req_ready, alu_opcode, alu_input1, alu_input2, alu_shift,
           rsp_valid, rsp_id, rsp_result, rsp_err, busy
  );
  modport slave (
    input  req_valid, req_opcode, req_a, req_b, req_shift, alu_result, rsp_ready,
    output req_ready, alu_opcode, alu_input1, alu_input2, alu_shift,
           rsp_valid, rsp_id, rsp_result, rsp_err, busy
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin issue of operations onto one shared combinational ALU.
// Define ALU_OPCODE_CHECK_EN to answer opcodes 8..15 directly with rsp_err=1 instead of executing them.
module alu_issue_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 128,
  parameter int DIV_CYCLES = 8
) (
  input logic clk,
  input logic rst_n,
  alu_issue_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(DIV_CYCLES + 1);
`ifdef ALU_OPCODE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d, id_q, id_d, win, idx;
  logic             any;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       opc_q, opc_d, w_opc;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [4:0]       sh_q, sh_d;
  logic             err_q, err_d;
  // Search ptr+1, ptr+2, ... wrapping; the last candidate is ptr itself.
  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (!any && bus.req_valid[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end
  assign w_opc = bus.req_opcode[int'(win)*4 +: 4];
  assign bus.req_ready = (state_q == IDLE && any) ? NUM_REQ'(1) << win : '0;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    opc_d   = opc_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    res_d   = res_q;
    err_d   = err_q;
    if (state_q == IDLE && any) begin
      ptr_d = win;
      id_d  = win;
      if (CHK && w_opc[3]) begin
        state_d = RESP;
        res_d   = '0;
        err_d   = 1'b1;
      end else begin
        state_d = EXEC;
        opc_d   = w_opc;
        a_d     = bus.req_a[int'(win)*WIDTH +: WIDTH];
        b_d     = bus.req_b[int'(win)*WIDTH +: WIDTH];
        sh_d    = bus.req_shift[int'(win)*5 +: 5];
        cnt_d   = (w_opc == 4'd7) ? CW'(DIV_CYCLES - 1) : '0;
      end
    end else if (state_q == EXEC) begin
      if (cnt_q == '0) begin
        state_d = RESP;
        res_d   = bus.alu_result;
        err_d   = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end else if (state_q == RESP && bus.rsp_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NUM_REQ - 1);
      id_q    <= '0;
      cnt_q   <= '0;
      opc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      opc_q   <= opc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end
  assign bus.alu_opcode = opc_q;
  assign bus.alu_input1 = a_q;
  assign bus.alu_input2 = b_q;
  assign bus.alu_shift  = sh_q;
  assign bus.rsp_valid  = state_q == RESP;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_err    = err_q;
  assign bus.busy       = state_q != IDLE;
endmodule
